// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of i_pwm_in in clock cycles, one result per period.
// Flags a stuck line when no rising edge arrives for TIMEOUT cycles and records the level it stuck at.
//
// state   | meaning
// IDLE    | after reset, waiting for the first accepted rising edge
// MEAS_HI | counting the high phase since the last rise
// MEAS_LO | counting the low phase; the next rise publishes duty/period
// STUCK   | no rise for TIMEOUT cycles; waiting for a rise to start measuring again
module pwm_capture #(
    parameter int CNT_W       = 11,
    parameter int TIMEOUT     = 1500,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pwm_in,
    output logic [CNT_W-1:0] o_duty,
    output logic [CNT_W-1:0] o_period,
    output logic             o_valid,
    output logic             o_stuck,
    output logic             o_stuck_level
);
    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, MEAS_HI, MEAS_LO, STUCK} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES:0]   r_fill;
    logic                   r_s_d;
    logic                   r_rise;
    logic                   r_fall;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hi_cap;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_s;
    logic                   w_tc;
    logic                   w_publish;
    logic                   w_to_stuck;
    logic                   w_stuck_lvl;

    assign w_s  = r_sync[SYNC_STAGES-1];
    assign w_tc = (r_cnt == LP_TIMEOUT);

    // r_fill masks edges until s and s_d both hold post-reset samples, so a line that is
    // already high at reset release does not produce a false first rise.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_fill <= '0;
            r_s_d  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm_in};
            r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
            r_s_d  <= w_s;
            r_rise <= r_fill[SYNC_STAGES] & w_s & ~r_s_d;
            r_fall <= r_fill[SYNC_STAGES] & ~w_s & r_s_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_hi_cap <= '0;
        end else begin
            if (r_rise) begin
                r_cnt <= CNT_W'(1);
            end else if (!w_tc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_fall) begin
                r_hi_cap <= r_cnt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_publish   = 1'b0;
        w_to_stuck  = 1'b0;
        w_stuck_lvl = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_rise) begin
                    w_state_nxt = MEAS_HI;
                end else if (w_tc) begin
                    w_state_nxt = STUCK;
                    w_to_stuck  = 1'b1;
                    w_stuck_lvl = w_s;
                end
            end
            MEAS_HI: begin
                if (r_fall) begin
                    w_state_nxt = MEAS_LO;
                end else if (w_tc) begin
                    w_state_nxt = STUCK;
                    w_to_stuck  = 1'b1;
                    w_stuck_lvl = 1'b1;
                end
            end
            MEAS_LO: begin
                // a rise coinciding with terminal count still yields a valid period of TIMEOUT
                if (r_rise) begin
                    w_state_nxt = MEAS_HI;
                    w_publish   = 1'b1;
                end else if (w_tc) begin
                    w_state_nxt = STUCK;
                    w_to_stuck  = 1'b1;
                    w_stuck_lvl = 1'b0;
                end
            end
            STUCK: begin
                if (r_rise) begin
                    w_state_nxt = MEAS_HI;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            o_duty        <= '0;
            o_period      <= '0;
            o_valid       <= 1'b0;
            o_stuck       <= 1'b0;
            o_stuck_level <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            o_valid <= w_publish;
            if (w_publish) begin
                o_duty   <= r_hi_cap;
                o_period <= r_cnt;
                o_stuck  <= 1'b0;
            end else if (w_to_stuck) begin
                o_stuck       <= 1'b1;
                o_stuck_level <= w_stuck_lvl;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: drives a per-cycle pwm waveform and predicts each published
// duty/period (and its cycle) from the sampled waveform with plain arithmetic.
`timescale 1ns/1ps
module tb_pwm_capture;
    localparam int CNT_W   = 11;
    localparam int TIMEOUT = 1500;
    localparam int SYNC    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm = 1'b0;
    logic [CNT_W-1:0] o_duty;
    logic [CNT_W-1:0] o_period;
    logic             o_valid;
    logic             o_stuck;
    logic             o_stuck_level;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pwm_in     (pwm),
        .o_duty       (o_duty),
        .o_period     (o_period),
        .o_valid      (o_valid),
        .o_stuck      (o_stuck),
        .o_stuck_level(o_stuck_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int duty;
        int per;
        int due;
    } exp_t;
    exp_t exp_q[$];

    // waveform model state
    bit m_seen      = 0;
    bit m_last      = 0;
    bit m_have_rise = 0;
    bit m_in_hi     = 0;
    int m_rise_cyc  = 0;
    int m_hi        = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock of stimulus; the model sees the value the DUT sampled at this edge
    task automatic step(input logic v);
        pwm = v;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_seen = 0;
            m_have_rise = 0;
            m_in_hi = 0;
            exp_q.delete();
        end else if (!m_seen) begin
            m_seen = 1;
            m_last = v;
        end else begin
            if (v && !m_last) begin
                if (m_have_rise && (cyc - m_rise_cyc) <= TIMEOUT)
                    exp_q.push_back('{duty: m_hi, per: cyc - m_rise_cyc, due: cyc + SYNC + 1});
                m_have_rise = 1;
                m_rise_cyc  = cyc;
                m_hi        = 0;
                m_in_hi     = 1;
            end else if (!v && m_last) begin
                m_in_hi = 0;
            end
            if (m_in_hi && v) m_hi++;
            m_last = v;
        end
    endtask

    task automatic drive_period(input int hi, input int per);
        for (int i = 0; i < hi; i++) step(1'b1);
        for (int i = 0; i < per - hi; i++) step(1'b0);
    endtask

    // hold the line and check stuck appears exactly TIMEOUT cycles after the last rise's publish slot
    task automatic hold_check(input logic lvl, input int n);
        int base;
        base = m_rise_cyc + SYNC + 1;
        for (int i = 0; i < n; i++) begin
            step(lvl);
            if (cyc == base + TIMEOUT - 1) chk("stuck_early", int'(o_stuck), 0);
            if (cyc == base + TIMEOUT) begin
                chk("stuck_set", int'(o_stuck), 1);
                chk("stuck_level", int'(o_stuck_level), int'(lvl));
            end
        end
    endtask

    always @(negedge clk) begin
        if (o_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL valid_spurious: valid=1 duty=%0d period=%0d at cycle %0d, expected no valid",
                         o_duty, o_period, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(o_duty) != e.duty || int'(o_period) != e.per || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL valid_data: got duty=%0d period=%0d cycle=%0d, expected duty=%0d period=%0d cycle=%0d",
                             o_duty, o_period, cyc, e.duty, e.per, e.due);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL valid_missing: got no valid by cycle %0d, expected duty=%0d period=%0d at cycle %0d",
                     cyc, exp_q[0].duty, exp_q[0].per, exp_q[0].due);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int hi;
        int per;
        int reps;
        int exp_duty;
        int exp_per;
    } vec_t;
    vec_t vecs[7];

    initial begin
        vecs[0] = '{hi: 300,  per: 1000, reps: 3, exp_duty: 300,  exp_per: 1000};
        vecs[1] = '{hi: 700,  per: 1000, reps: 2, exp_duty: 700,  exp_per: 1000};
        vecs[2] = '{hi: 1,    per: 2,    reps: 4, exp_duty: 1,    exp_per: 2};
        vecs[3] = '{hi: 2,    per: 3,    reps: 3, exp_duty: 2,    exp_per: 3};
        vecs[4] = '{hi: 5,    per: 7,    reps: 3, exp_duty: 5,    exp_per: 7};
        vecs[5] = '{hi: 1499, per: 1500, reps: 2, exp_duty: 1499, exp_per: 1500};
        vecs[6] = '{hi: 1,    per: 1500, reps: 2, exp_duty: 1,    exp_per: 1500};

        // reset held while the input toggles
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) step(i[0]);
        chk("rst_duty", int'(o_duty), 0);
        chk("rst_period", int'(o_period), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_stuck", int'(o_stuck), 0);
        rst_n = 1'b1;
        step(1'b0);

        // steady waveforms, duty step, minimum period, period == TIMEOUT
        for (int v = 0; v < 7; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) drive_period(vecs[v].hi, vecs[v].per);
            for (int i = 0; i < SYNC + 2; i++) step(1'b0);
            chk("tbl_duty", int'(o_duty), vecs[v].exp_duty);
            chk("tbl_period", int'(o_period), vecs[v].exp_per);
        end

        // stuck low, then recovery needs one full period
        drive_period(300, 1000);
        drive_period(300, 1000);
        chk("stuck_clear_pre", int'(o_stuck), 0);
        for (int i = 0; i < 300; i++) step(1'b1);
        hold_check(1'b0, TIMEOUT + 10);
        drive_period(300, 1000);
        chk("stuck_hold_first_rise", int'(o_stuck), 1);
        drive_period(300, 1000);
        chk("stuck_clear_valid", int'(o_stuck), 0);
        chk("stuck_recover_duty", int'(o_duty), 300);

        // stuck high, then minimum waveform
        step(1'b1);
        hold_check(1'b1, TIMEOUT + SYNC + 5);
        for (int i = 0; i < 10; i++) step(1'b0);
        for (int i = 0; i < 5; i++) drive_period(1, 2);
        for (int i = 0; i < SYNC + 2; i++) step(1'b0);
        chk("min_duty", int'(o_duty), 1);
        chk("min_period", int'(o_period), 2);
        chk("min_stuck_clear", int'(o_stuck), 0);

        // randomized waveforms
        for (int i = 0; i < 40; i++) begin
            int per;
            int hi;
            per = int'($urandom_range(200, 2));
            hi  = int'($urandom_range(per - 1, 1));
            drive_period(hi, per);
        end

        // reset mid high phase
        drive_period(300, 1000);
        drive_period(300, 1000);
        for (int i = 0; i < 100; i++) step(1'b1);
        rst_n = 1'b0;
        step(1'b1);
        rst_n = 1'b1;
        chk("midrst_duty", int'(o_duty), 0);
        chk("midrst_period", int'(o_period), 0);
        chk("midrst_valid", int'(o_valid), 0);
        chk("midrst_stuck", int'(o_stuck), 0);
        for (int i = 0; i < 199; i++) step(1'b1);
        for (int i = 0; i < 700; i++) step(1'b0);
        drive_period(300, 1000);
        drive_period(300, 1000);
        for (int i = 0; i < SYNC + 2; i++) step(1'b0);
        chk("postrst_duty", int'(o_duty), 300);
        chk("postrst_period", int'(o_period), 1000);

        for (int i = 0; i < SYNC + 3; i++) step(1'b0);
        chk("pending_valids", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
